// File: rtl/cpu_seq.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE -> WRITE_BACK, with HALT on fetch timeout.
// Optional CPU_SEQ_ALIGN_TRAP_EN: a misaligned control-flow target faults into HALT instead of being forced to word alignment.
module cpu_seq #(
    parameter int unsigned ADDR_W    = 7,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int unsigned FETCH_TMO = 15
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       insn,
    input  logic [4:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rd,
    input  logic [31:0]       imm,
    input  logic [31:0]       rs1_val,
    input  logic [31:0]       rs2_val,
    input  logic [31:0]       alu_out,
    output logic              rf_rden,
    output logic              rf_wren,
    output logic [31:0]       rf_wdata,
    output logic [31:0]       pc,
    output logic [2:0]        state,
    output logic              fault
);

    typedef enum logic [2:0] {
        ST_FETCH      = 3'd0,
        ST_DECODE     = 3'd1,
        ST_EXECUTE    = 3'd2,
        ST_WRITE_BACK = 3'd3,
        ST_HALT       = 3'd4
    } state_e;

    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam int unsigned CNT_W     = $clog2(FETCH_TMO + 1);

    function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] next_pc(input logic [4:0] opc, input logic [2:0] f3, input logic [31:0] im,
                                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] cur);
        case (opc)
            OPC_JAL:    return cur + im;
            OPC_JALR:   return (a + im) & 32'hFFFF_FFFE;
            OPC_BRANCH: return br_taken(f3, a, b) ? (cur + im) : (cur + 32'd4);
            default:    return cur + 32'd4;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [4:0] opc, input logic [4:0] rdn);
        case (opc)
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: return rdn != 5'd0;
            default:                                                  return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] wb_data(input logic [4:0] opc, input logic [31:0] im,
                                            input logic [31:0] alu, input logic [31:0] cur);
        case (opc)
            OPC_JAL, OPC_JALR: return cur + 32'd4;
            OPC_AUIPC:         return cur + im;
            OPC_LUI:           return im;
            default:           return alu;
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d, insn_q, insn_d;
    logic               req_q, req_d, rden_q, rden_d, wren_q, wren_d, fault_q, fault_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic [4:0]         opc_q, opc_d;
    logic [2:0]         f3_q, f3_d;
    logic [31:0]        imm_q, imm_d, rs1_q, rs1_d, rs2_q, rs2_d, alu_q, alu_d;
    logic [31:0]        npc_s;

    // Target computed from the operands captured in EXECUTE; used on the WRITE_BACK edge.
    assign npc_s = next_pc(opc_q, f3_q, imm_q, rs1_q, rs2_q, pc_q);

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        insn_d  = insn_q;
        req_d   = req_q;
        rden_d  = rden_q;
        wren_d  = wren_q;
        fault_d = fault_q;
        wait_d  = wait_q;
        opc_d   = opc_q;
        f3_d    = f3_q;
        imm_d   = imm_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        alu_d   = alu_q;
        case (state_q)
            ST_FETCH: begin
                if (req_q && imem_ack) begin
                    insn_d  = imem_rdata;
                    req_d   = 1'b0;
                    rden_d  = 1'b1;
                    wait_d  = {CNT_W{1'b0}};
                    state_d = ST_DECODE;
                end else if (req_q && (wait_q == CNT_W'(FETCH_TMO - 1))) begin
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    wait_d  = {CNT_W{1'b0}};
                    state_d = ST_HALT;
                end else if (req_q) begin
                    wait_d  = wait_q + CNT_W'(1);
                end else begin
                    req_d   = 1'b1;
                end
            end
            ST_DECODE: begin
                rden_d  = 1'b0;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                opc_d   = opcode;
                f3_d    = funct3;
                imm_d   = imm;
                rs1_d   = rs1_val;
                rs2_d   = rs2_val;
                alu_d   = alu_out;
`ifdef CPU_SEQ_ALIGN_TRAP_EN
                wren_d  = writes_rd(opcode, rd) &&
                          (next_pc(opcode, funct3, imm, rs1_val, rs2_val, pc_q) & 32'd3) == 32'd0;
`else
                wren_d  = writes_rd(opcode, rd);
`endif
                state_d = ST_WRITE_BACK;
            end
            ST_WRITE_BACK: begin
                wren_d = 1'b0;
`ifdef CPU_SEQ_ALIGN_TRAP_EN
                if (npc_s[1:0] != 2'b00) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    pc_d    = npc_s;
                    req_d   = 1'b1;
                    state_d = ST_FETCH;
                end
`else
                pc_d    = {npc_s[31:2], 2'b00};
                req_d   = 1'b1;
                state_d = ST_FETCH;
`endif
            end
            ST_HALT: begin
                req_d  = 1'b0;
                rden_d = 1'b0;
                wren_d = 1'b0;
            end
            default: begin
                req_d   = 1'b0;
                rden_d  = 1'b0;
                wren_d  = 1'b0;
                fault_d = 1'b1;
                state_d = ST_HALT;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            insn_q  <= 32'h0;
            req_q   <= 1'b0;
            rden_q  <= 1'b0;
            wren_q  <= 1'b0;
            fault_q <= 1'b0;
            wait_q  <= {CNT_W{1'b0}};
            opc_q   <= 5'h0;
            f3_q    <= 3'h0;
            imm_q   <= 32'h0;
            rs1_q   <= 32'h0;
            rs2_q   <= 32'h0;
            alu_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            insn_q  <= insn_d;
            req_q   <= req_d;
            rden_q  <= rden_d;
            wren_q  <= wren_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
            opc_q   <= opc_d;
            f3_q    <= f3_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            alu_q   <= alu_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q[ADDR_W+1:2];
    assign insn      = insn_q;
    assign rf_rden   = rden_q;
    assign rf_wren   = wren_q;
    assign rf_wdata  = wb_data(opc_q, imm_q, alu_q, pc_q);
    assign pc        = pc_q;
    assign state     = state_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Directed self-checking bench for cpu_seq; the decoder and register file are modelled by driving their outputs directly.
module tb_cpu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack;
    logic [6:0]  imem_addr;
    logic [31:0] imem_rdata, insn, imm, rs1_val, rs2_val, alu_out, rf_wdata, pc;
    logic [4:0]  opcode, rd;
    logic [2:0]  funct3, state;
    logic        rf_rden, rf_wren, fault;

    int n_checks = 0;
    int n_errors = 0;

    cpu_seq dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .insn(insn), .opcode(opcode), .funct3(funct3), .rd(rd), .imm(imm),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .alu_out(alu_out),
        .rf_rden(rf_rden), .rf_wren(rf_wren), .rf_wdata(rf_wdata),
        .pc(pc), .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH (imem_req already high); returns cycles to FETCH/HALT and any write seen.
    task automatic run_insn(input logic [31:0] w, input int stall, input logic [4:0] opc, input logic [2:0] f3,
                            input logic [4:0] rdn, input logic [31:0] im, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] alu,
                            output int cyc, output logic wr_seen, output logic [31:0] wd_seen);
        opcode = opc; funct3 = f3; rd = rdn; imm = im;
        rs1_val = a; rs2_val = b; alu_out = alu; imem_rdata = w;
        cyc = 0; wr_seen = 1'b0; wd_seen = 32'h0; imem_ack = 1'b0;
        repeat (stall) begin tick(); cyc++; end
        imem_ack = 1'b1;
        tick(); cyc++;
        imem_ack = 1'b0;
        check("insn_latch", insn, w);
        while (state != 3'd0 && state != 3'd4 && cyc < 40) begin
            if (rf_wren) begin wr_seen = 1'b1; wd_seen = rf_wdata; end
            tick(); cyc++;
        end
        check("insn_done", {31'b0, cyc < 40}, 32'd1);
    endtask

    task automatic exec_chk(input string tag, input logic [31:0] w, input logic [4:0] opc, input logic [2:0] f3,
                            input logic [4:0] rdn, input logic [31:0] im, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] alu,
                            input logic [31:0] exp_pc, input logic exp_wr, input logic [31:0] exp_wd);
        int c; logic ws; logic [31:0] wd;
        run_insn(w, 0, opc, f3, rdn, im, a, b, alu, c, ws, wd);
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_state"}, state, 32'd0);
        check({tag, "_wren"}, ws, exp_wr);
        if (exp_wr) check({tag, "_wdata"}, wd, exp_wd);
    endtask

    initial begin
        int c; logic ws; logic [31:0] wd;
        imem_ack = 1'b0; imem_rdata = 32'h0; opcode = 5'h0; funct3 = 3'h0; rd = 5'h0;
        imm = 32'h0; rs1_val = 32'h0; rs2_val = 32'h0; alu_out = 32'h0;

        // Reset values
        #3 rst = 1'b0;
        repeat (2) tick();
        check("rst_state", state, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_req", imem_req, 32'd0);
        check("rst_insn", insn, 32'h0);
        check("rst_fault", fault, 32'd0);
        check("rst_strobes", {rf_rden, rf_wren}, 32'd0);
        rst = 1'b1;
        tick();
        check("req_after_rst", imem_req, 32'd1);

        // Fetch stall of 3 cycles, ADDI x1,x0,5
        run_insn(32'h00500093, 3, 5'b00100, 3'b000, 5'd1, 32'd5, 32'd0, 32'd0, 32'd5, c, ws, wd);
        check("stall_cycles", c, 32'd7);
        check("stall_pc", pc, 32'h4);
        check("stall_wren", ws, 32'd1);
        check("stall_wdata", wd, 32'd5);

        exec_chk("nop", 32'h00000013, 5'b00100, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h8, 1'b0, 32'h0);
        exec_chk("blt", 32'h0010c863, 5'b11000, 3'b100, 5'd0, 32'd16, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd24, 1'b0, 32'h0);
        exec_chk("jal_back", 32'hff1ff06f, 5'b11011, 3'b000, 5'd0, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0, 32'h8, 1'b0, 32'h0);
        exec_chk("bltu", 32'h0010e863, 5'b11000, 3'b110, 5'd0, 32'd16, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd12, 1'b0, 32'h0);
        exec_chk("jal_to20", 32'h0140006f, 5'b11011, 3'b000, 5'd0, 32'd20, 32'd0, 32'd0, 32'd0, 32'h20, 1'b0, 32'h0);
        exec_chk("jalr_rd1", 32'h004080e7, 5'b11001, 3'b000, 5'd1, 32'd4, 32'h101, 32'd0, 32'd0, 32'h104, 1'b1, 32'h24);
        exec_chk("jal_back20", 32'hf1dff06f, 5'b11011, 3'b000, 5'd0, 32'hFFFF_FF1C, 32'd0, 32'd0, 32'd0, 32'h20, 1'b0, 32'h0);
        exec_chk("jalr_rd0", 32'h00408067, 5'b11001, 3'b000, 5'd0, 32'd4, 32'h101, 32'd0, 32'd0, 32'h104, 1'b0, 32'h0);
        exec_chk("br_f3_010", 32'h00102863, 5'b11000, 3'b010, 5'd0, 32'd16, 32'd0, 32'd1, 32'd0, 32'h108, 1'b0, 32'h0);
        exec_chk("beq", 32'hfe738ce3, 5'b11000, 3'b000, 5'd0, 32'hFFFF_FFF8, 32'd7, 32'd7, 32'd0, 32'h100, 1'b0, 32'h0);
        check("addr_0x100", imem_addr, 32'h40);
        exec_chk("jal_0x300", 32'h2000006f, 5'b11011, 3'b000, 5'd0, 32'h200, 32'd0, 32'd0, 32'd0, 32'h300, 1'b0, 32'h0);
        check("addr_alias", imem_addr, 32'h40);
        exec_chk("lui", 32'h12345137, 5'b01101, 3'b000, 5'd2, 32'h1234_5000, 32'd0, 32'd0, 32'hDEAD_BEEF, 32'h304, 1'b1, 32'h1234_5000);
        exec_chk("auipc", 32'h00001197, 5'b00101, 3'b000, 5'd3, 32'h1000, 32'd0, 32'd0, 32'hDEAD_BEEF, 32'h308, 1'b1, 32'h1304);
        exec_chk("jal_top", 32'hcf5ff06f, 5'b11011, 3'b000, 5'd0, 32'hFFFF_FCF4, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 1'b0, 32'h0);
        check("addr_top", imem_addr, 32'h7F);
        exec_chk("wrap", 32'h00000013, 5'b00100, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h0, 1'b0, 32'h0);
        check("addr_wrap", imem_addr, 32'h0);

        // JAL to a misaligned target
`ifdef CPU_SEQ_ALIGN_TRAP_EN
        run_insn(32'h006000ef, 0, 5'b11011, 3'b000, 5'd1, 32'd6, 32'd0, 32'd0, 32'd0, c, ws, wd);
        check("mis_fault", fault, 32'd1);
        check("mis_state", state, 32'd4);
        check("mis_pc", pc, 32'h0);
        check("mis_wren", ws, 32'd0);
`else
        exec_chk("mis", 32'h006000ef, 5'b11011, 3'b000, 5'd1, 32'd6, 32'd0, 32'd0, 32'd0, 32'h4, 1'b1, 32'h4);
        check("mis_fault", fault, 32'd0);
`endif

        // Reset in the middle of EXECUTE
        rst = 1'b0; tick(); rst = 1'b1; tick();
        exec_chk("pre_rst", 32'h00000013, 5'b00100, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h4, 1'b0, 32'h0);
        opcode = 5'b00100; rd = 5'd1; alu_out = 32'd9; imem_rdata = 32'h00900093;
        imem_ack = 1'b1; tick(); imem_ack = 1'b0;
        tick();
        check("mid_exec_state", state, 32'd2);
        rst = 1'b0;
        #1;
        check("arst_state", state, 32'd0);
        check("arst_pc", pc, 32'h0);
        check("arst_wren", rf_wren, 32'd0);
        ws = 1'b0;
        repeat (3) begin tick(); ws = ws | rf_wren; end
        check("arst_no_write", ws, 32'd0);

        // Fetch timeout
        rst = 1'b1;
        check("tmo_req_pre", imem_req, 32'd0);
        tick();
        check("tmo_req", imem_req, 32'd1);
        c = 0;
        while (state != 3'd4 && c < 40) begin tick(); c++; end
        check("tmo_cycles", c, 32'd15);
        check("tmo_fault", fault, 32'd1);
        check("tmo_req_off", imem_req, 32'd0);
        imem_ack = 1'b1; repeat (3) tick(); imem_ack = 1'b0;
        check("halt_state", state, 32'd4);
        check("halt_pc", pc, 32'h0);
        check("halt_strobes", {imem_req, rf_rden, rf_wren}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
